// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg
// Shared types and constants for the MEM-stage data bus bridge.
//   state_t     : bridge FSM states
//   WORD_W      : data/address width
//   ALIGN_MASK  : byte-offset bits that must be zero for a word access
//   is_aligned  : word-alignment test on the low address bits
package mem_bridge_pkg;

   localparam int         WORD_W     = 32;
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic is_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/watchdog_counter.sv
// watchdog_counter
// Cycle counter that flags when an access has been waiting too long.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  restart the count from zero (wins over en)
//   en      in  count one cycle
//   expired out count has reached TIMEOUT-1
module watchdog_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The owner only consults this while counting, so it is not gated by en.
   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
// Turns a single-cycle MEM-stage load/store into a req/ready/rvalid bus
// transaction and freezes the pipeline with mem_stall until it completes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      MEM-stage access request (both set = write + err)
//   addr, wdata              byte address and store data
//   rdata                    registered load data for MEM/WB
//   mem_stall                combinational pipeline freeze
//   err, err_clr             sticky misalign/timeout/conflict flag and its clear
//   bus_req/we/addr/wdata    registered bus request, held while in REQ
//   bus_ready, bus_rvalid,
//   bus_rdata                bus handshake and read return
module data_mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              mem_stall,
   output logic              err,
   input  logic              err_clr,
   output logic              bus_req,
   output logic              bus_we,
   output logic [WORD_W-1:0] bus_addr,
   output logic [WORD_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic              bus_rvalid,
   input  logic [WORD_W-1:0] bus_rdata
);

   state_t            state_q, state_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic [WORD_W-1:0] bus_addr_q, bus_addr_d;
   logic [WORD_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              bus_we_q, bus_we_d;
   logic              bus_req_q, bus_req_d;
   logic              err_q, err_d;

   logic access, aligned, err_set;
   logic wd_clr, wd_en, wd_expired;

   assign access  = mem_read | mem_write;
   assign aligned = is_aligned(addr[1:0]);
   assign wd_en   = (state_q == REQ) || (state_q == WAIT_R);

   watchdog_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      rdata_d     = rdata_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_we_d    = bus_we_q;
      bus_req_d   = bus_req_q;
      err_set     = 1'b0;
      wd_clr      = 1'b0;
      mem_stall   = 1'b0;

      case (state_q)
         IDLE: begin
            if (access) begin
               if (mem_read && mem_write) begin
                  err_set = 1'b1;
               end
               if (aligned) begin
                  // Stall already in the IDLE cycle so the access is held
                  // steady while the request is being launched.
                  mem_stall   = 1'b1;
                  bus_we_d    = mem_write;
                  bus_addr_d  = {addr[WORD_W-1:2], addr[1:0] & ~ALIGN_MASK};
                  bus_wdata_d = wdata;
                  bus_req_d   = 1'b1;
                  wd_clr      = 1'b1;
                  state_d     = REQ;
               end else begin
                  // Misaligned: flag it and let the pipeline move on.
                  err_set = 1'b1;
               end
            end
         end

         REQ: begin
            mem_stall = 1'b1;
            if (bus_ready) begin
               // A handshake in the expiring cycle still counts as success.
               bus_req_d = 1'b0;
               if (bus_we_q) begin
                  state_d = DONE;
               end else begin
                  wd_clr  = 1'b1;
                  state_d = WAIT_R;
               end
            end else if (wd_expired) begin
               bus_req_d = 1'b0;
               rdata_d   = '0;
               err_set   = 1'b1;
               state_d   = DONE;
            end
         end

         WAIT_R: begin
            mem_stall = 1'b1;
            if (bus_rvalid) begin
               rdata_d = bus_rdata;
               state_d = DONE;
            end else if (wd_expired) begin
               rdata_d = '0;
               err_set = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            // One unstalled cycle lets the pipeline advance past this access.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Set outranks clear when both land in the same cycle.
      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (err_set) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         rdata_q     <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_we_q    <= 1'b0;
         bus_req_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_we_q    <= bus_we_d;
         bus_req_q   <= bus_req_d;
         err_q       <= err_d;
      end
   end

   assign rdata     = rdata_q;
   assign err       = err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;

endmodule
